// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// Holds the memory ALU op codes, the alignment exception bit positions,
// the access FSM state type, and the op decoder used by the top and the lane mux.
package mem_access_pkg;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

    localparam int unsigned EXC_ADEL_BIT = 13;
    localparam int unsigned EXC_ADES_BIT = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ABORT
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    typedef struct packed {
        logic  is_mem;
        logic  is_load;
        logic  is_store;
        logic  is_signed;
        logic  is_ll;
        logic  is_sc;
        size_t size;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t d;
        d.is_mem    = 1'b1;
        d.is_load   = 1'b0;
        d.is_store  = 1'b0;
        d.is_signed = 1'b0;
        d.is_ll     = 1'b0;
        d.is_sc     = 1'b0;
        d.size      = SZ_WORD;
        case (op)
            EXE_LB_OP:  begin d.is_load  = 1'b1; d.is_signed = 1'b1; d.size = SZ_BYTE; end
            EXE_LBU_OP: begin d.is_load  = 1'b1; d.size = SZ_BYTE; end
            EXE_LH_OP:  begin d.is_load  = 1'b1; d.is_signed = 1'b1; d.size = SZ_HALF; end
            EXE_LHU_OP: begin d.is_load  = 1'b1; d.size = SZ_HALF; end
            EXE_LW_OP:  d.is_load = 1'b1;
            EXE_LL_OP:  begin d.is_load  = 1'b1; d.is_ll = 1'b1; end
            EXE_SB_OP:  begin d.is_store = 1'b1; d.size = SZ_BYTE; end
            EXE_SH_OP:  begin d.is_store = 1'b1; d.size = SZ_HALF; end
            EXE_SW_OP:  d.is_store = 1'b1;
            EXE_SC_OP:  begin d.is_store = 1'b1; d.is_sc = 1'b1; end
            default:    d.is_mem = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus request/acknowledge interface between the MEM stage and data memory.
//   req   : request, held until ack      we    : 1 = write
//   sel   : byte enables, sel[3] = byte 0 (big-endian)
//   addr  : word address                  wdata : store data, replicated to lanes
//   ack   : one-cycle transfer complete   rdata : read data, valid with ack
interface mem_access_if;
    logic        req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, sel, addr, wdata, input ack, rdata);
    modport slave  (input req, we, sel, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_lane_mux.sv
// Big-endian byte-lane steering for the data bus.
//   size/is_signed : access width and load extension mode
//   addr_lo        : address bits [1:0]
//   store_data     : rt value; wdata is it replicated across lanes
//   rdata          : captured read word; load_data is the extracted, extended value
//   sel            : byte enables (sel[3] = byte address 0)
module mem_access_lane_mux
    import mem_access_pkg::*;
(
    input  size_t       size,
    input  logic        is_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  sel,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_val = rdata[31:24];
            2'd1:    byte_val = rdata[23:16];
            2'd2:    byte_val = rdata[15:8];
            default: byte_val = rdata[7:0];
        endcase
        half_val = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    always_comb begin
        sel       = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
        unique case (size)
            SZ_BYTE: begin
                sel       = 4'b1000 >> addr_lo;
                wdata     = {4{store_data[7:0]}};
                load_data = is_signed ? {{24{byte_val[7]}}, byte_val} : {24'd0, byte_val};
            end
            SZ_HALF: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata     = {2{store_data[15:0]}};
                load_data = is_signed ? {{16{half_val[15]}}, half_val} : {16'd0, half_val};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit of the 5-stage MIPS pipeline.
// Runs the req/ack data-bus FSM for loads and stores, checks alignment,
// tracks the LL/SC link bit and stalls the front of the pipe while busy.
//   clk, rst        : clock, synchronous active-high reset
//   mem_*           : ex_mem register outputs (dest, op, address, rt, exceptions)
//   flush           : pipeline flush
//   dbus            : data-bus master port (registered)
//   wb_*            : result towards mem_wb (combinational)
//   excepttype_o    : upstream exceptions plus AdEL/AdES
//   bad_vaddr       : faulting address when AdEL/AdES raised
//   llbit_o         : current link bit
//   stallreq        : stall request to ctrl
module mem_access
    import mem_access_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [4:0]         mem_wd,
    input  logic               mem_wreg,
    input  logic [31:0]        mem_wdata,
    input  logic [7:0]         mem_aluop,
    input  logic [31:0]        mem_mem_addr,
    input  logic [31:0]        mem_reg2,
    input  logic [31:0]        mem_excepttype,
    input  logic               flush,
    mem_access_if.master       dbus,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [31:0]        wb_wdata,
    output logic [31:0]        excepttype_o,
    output logic [31:0]        bad_vaddr,
    output logic               llbit_o,
    output logic               stallreq
);

    state_t      state;
    logic        llbit;
    logic [31:0] rdata_q;

    op_info_t    op;
    logic        misaligned;
    logic        no_exc;
    logic        sc_fail;
    logic        start;

    logic [3:0]  lane_sel;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    assign op      = decode_op(mem_aluop);
    assign no_exc  = (mem_excepttype == '0);
    assign sc_fail = op.is_sc && !llbit;
    assign llbit_o = llbit;

    always_comb begin
        misaligned = 1'b0;
        if (ALIGN_CHECK && op.is_mem) begin
            unique case (op.size)
                SZ_HALF: misaligned = mem_mem_addr[0];
                SZ_WORD: misaligned = (mem_mem_addr[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end
    end

    assign start = op.is_mem && !misaligned && no_exc && !flush && !sc_fail;

    mem_access_lane_mux u_lane_mux (
        .size       (op.size),
        .is_signed  (op.is_signed),
        .addr_lo    (mem_mem_addr[1:0]),
        .store_data (mem_reg2),
        .rdata      (rdata_q),
        .sel        (lane_sel),
        .wdata      (lane_wdata),
        .load_data  (load_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            llbit      <= 1'b0;
            rdata_q    <= '0;
            dbus.req   <= 1'b0;
            dbus.we    <= 1'b0;
            dbus.sel   <= '0;
            dbus.addr  <= '0;
            dbus.wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_REQ;
                        dbus.req   <= 1'b1;
                        dbus.we    <= op.is_store;
                        dbus.sel   <= lane_sel;
                        dbus.addr  <= {mem_mem_addr[31:2], 2'b00};
                        dbus.wdata <= op.is_store ? lane_wdata : '0;
                    end
                end
                ST_REQ: begin
                    if (dbus.ack) begin
                        dbus.req <= 1'b0;
                        if (flush) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DONE;
                            rdata_q <= dbus.rdata;
                            if (op.is_ll) llbit <= 1'b1;
                            if (op.is_sc) llbit <= 1'b0;
                        end
                    end else if (flush) begin
                        // Bus transfer cannot be cancelled; wait out the ack and drop it.
                        state <= ST_ABORT;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ABORT: begin
                    if (dbus.ack) begin
                        dbus.req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
            endcase
            // Placed last so a flush overrides an LL completing in the same cycle.
            if (flush) llbit <= 1'b0;
        end
    end

    always_comb begin
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        excepttype_o = mem_excepttype;
        bad_vaddr    = '0;
        stallreq     = 1'b0;
        if (rst) begin
            wb_wd        = '0;
            wb_wreg      = 1'b0;
            wb_wdata     = '0;
            excepttype_o = '0;
        end else if (op.is_mem) begin
            wb_wreg  = 1'b0;
            wb_wdata = '0;
            if (misaligned) begin
                bad_vaddr = mem_mem_addr;
                if (op.is_load) excepttype_o[EXC_ADEL_BIT] = 1'b1;
                else            excepttype_o[EXC_ADES_BIT] = 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    stallreq = start;
                    // Failed SC writes 0 to rt without touching the bus.
                    if (sc_fail && !misaligned && no_exc && !flush) wb_wreg = 1'b1;
                end
                ST_REQ:   stallreq = !flush;
                ST_DONE: begin
                    if (op.is_sc) begin
                        wb_wreg  = 1'b1;
                        wb_wdata = 32'd1;
                    end else if (op.is_load) begin
                        wb_wreg  = mem_wreg;
                        wb_wdata = load_data;
                    end
                end
                ST_ABORT: stallreq = start;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] mem_excepttype;
    logic        flush;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] excepttype_o;
    logic [31:0] bad_vaddr;
    logic        llbit_o;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    mem_access_if dbus_if ();

    mem_access #(.ALIGN_CHECK(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wd         (mem_wd),
        .mem_wreg       (mem_wreg),
        .mem_wdata      (mem_wdata),
        .mem_aluop      (mem_aluop),
        .mem_mem_addr   (mem_mem_addr),
        .mem_reg2       (mem_reg2),
        .mem_excepttype (mem_excepttype),
        .flush          (flush),
        .dbus           (dbus_if.master),
        .wb_wd          (wb_wd),
        .wb_wreg        (wb_wreg),
        .wb_wdata       (wb_wdata),
        .excepttype_o   (excepttype_o),
        .bad_vaddr      (bad_vaddr),
        .llbit_o        (llbit_o),
        .stallreq       (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] rt);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = rt;
        mem_wd       = 5'd3;
        mem_wreg     = 1'b1;
        mem_wdata    = 32'h1111_1111;
        #1;
    endtask

    task automatic nop();
        mem_aluop    = 8'h00;
        mem_mem_addr = '0;
        mem_reg2     = '0;
        mem_wd       = 5'd7;
        mem_wreg     = 1'b1;
        mem_wdata    = 32'h0000_0011;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        mem_excepttype = '0;
        dbus_if.ack = 1'b0;
        dbus_if.rdata = '0;
        nop();
        tick();
        tick();

        // Reset state
        chk("rst_req", dbus_if.req, 0);
        chk("rst_addr", dbus_if.addr, 0);
        chk("rst_sel", dbus_if.sel, 0);
        chk("rst_stall", stallreq, 0);
        chk("rst_wb_wdata", wb_wdata, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_llbit", llbit_o, 0);
        rst = 1'b0;
        #1;
        chk("nop_pass_wdata", wb_wdata, 32'h11);
        chk("nop_stall", stallreq, 0);

        // LB 0x1003, ack in first REQ cycle
        set_op(EXE_LB_OP, 32'h0000_1003, 32'h0);
        chk("lb_stall_idle", stallreq, 1);
        chk("lb_no_req_yet", dbus_if.req, 0);
        tick();
        chk("lb_req", dbus_if.req, 1);
        chk("lb_sel", dbus_if.sel, 4'b0001);
        chk("lb_addr", dbus_if.addr, 32'h0000_1000);
        chk("lb_we", dbus_if.we, 0);
        chk("lb_stall_req", stallreq, 1);
        dbus_if.ack = 1'b1;
        dbus_if.rdata = 32'h1122_33F4;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("lb_req_drop", dbus_if.req, 0);
        chk("lb_stall_done", stallreq, 0);
        chk("lb_wb_wreg", wb_wreg, 1);
        chk("lb_wb_wdata", wb_wdata, 32'hFFFF_FFF4);
        nop();
        tick();

        // SH 0x2002
        set_op(EXE_SH_OP, 32'h0000_2002, 32'h0000_ABCD);
        tick();
        chk("sh_we", dbus_if.we, 1);
        chk("sh_sel", dbus_if.sel, 4'b0011);
        chk("sh_wdata", dbus_if.wdata, 32'hABCD_ABCD);
        chk("sh_addr", dbus_if.addr, 32'h0000_2000);
        chk("sh_wb_wreg_req", wb_wreg, 0);
        dbus_if.ack = 1'b1;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("sh_wb_wreg_done", wb_wreg, 0);
        chk("sh_stall_done", stallreq, 0);
        nop();
        tick();

        // Misaligned LW -> AdEL, misaligned SW -> AdES
        set_op(EXE_LW_OP, 32'h0000_3001, 32'h0);
        chk("lw_mis_exc", excepttype_o, 32'h0000_2000);
        chk("lw_mis_badva", bad_vaddr, 32'h0000_3001);
        chk("lw_mis_stall", stallreq, 0);
        chk("lw_mis_wreg", wb_wreg, 0);
        tick();
        chk("lw_mis_noreq", dbus_if.req, 0);
        set_op(EXE_SW_OP, 32'h0000_3002, 32'h0);
        chk("sw_mis_exc", excepttype_o, 32'h0000_4000);
        tick();
        chk("sw_mis_noreq", dbus_if.req, 0);

        // LL then SC
        set_op(EXE_LL_OP, 32'h0000_4000, 32'h0);
        tick();
        chk("ll_sel", dbus_if.sel, 4'b1111);
        dbus_if.ack = 1'b1;
        dbus_if.rdata = 32'hDEAD_BEEF;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("ll_wb_wdata", wb_wdata, 32'hDEAD_BEEF);
        chk("ll_llbit", llbit_o, 1);
        nop();
        tick();
        set_op(EXE_SC_OP, 32'h0000_4000, 32'd5);
        chk("sc_stall", stallreq, 1);
        tick();
        chk("sc_req", dbus_if.req, 1);
        chk("sc_we", dbus_if.we, 1);
        chk("sc_wdata", dbus_if.wdata, 32'd5);
        dbus_if.ack = 1'b1;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("sc_wb_wdata", wb_wdata, 32'd1);
        chk("sc_wb_wreg", wb_wreg, 1);
        chk("sc_llbit_clr", llbit_o, 0);
        nop();
        tick();

        // LL, flush, then SC must fail
        set_op(EXE_LL_OP, 32'h0000_4000, 32'h0);
        tick();
        dbus_if.ack = 1'b1;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("ll2_llbit", llbit_o, 1);
        nop();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("flush_llbit", llbit_o, 0);
        set_op(EXE_SC_OP, 32'h0000_4000, 32'd5);
        chk("scf_stall", stallreq, 0);
        chk("scf_wb_wdata", wb_wdata, 0);
        chk("scf_wb_wreg", wb_wreg, 1);
        tick();
        chk("scf_noreq", dbus_if.req, 0);

        // LL with delayed ack, flushed in second REQ cycle; new LBU waits
        set_op(EXE_LL_OP, 32'h0000_6000, 32'h0);
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("abt_flush_stall", stallreq, 0);
        chk("abt_flush_wreg", wb_wreg, 0);
        tick();
        flush = 1'b0;
        set_op(EXE_LBU_OP, 32'h0000_7001, 32'h0);
        chk("abt_req_held", dbus_if.req, 1);
        chk("abt_stall_new", stallreq, 1);
        chk("abt_wreg", wb_wreg, 0);
        chk("abt_llbit", llbit_o, 0);
        tick();
        chk("abt_req_held2", dbus_if.req, 1);
        dbus_if.ack = 1'b1;
        dbus_if.rdata = 32'hCAFE_BABE;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("abt_req_drop", dbus_if.req, 0);
        chk("abt_llbit_after", llbit_o, 0);
        chk("abt_wreg_after", wb_wreg, 0);
        tick();
        chk("lbu7_sel", dbus_if.sel, 4'b0100);
        chk("lbu7_addr", dbus_if.addr, 32'h0000_7000);
        dbus_if.ack = 1'b1;
        dbus_if.rdata = 32'h00AB_0000;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("lbu7_wb_wdata", wb_wdata, 32'h0000_00AB);
        nop();
        tick();

        // Reset in the middle of a request
        set_op(EXE_LW_OP, 32'h0000_8000, 32'h0);
        tick();
        chk("rstmid_req", dbus_if.req, 1);
        rst = 1'b1;
        tick();
        chk("rstmid_req_drop", dbus_if.req, 0);
        chk("rstmid_stall", stallreq, 0);
        chk("rstmid_wb_wdata", wb_wdata, 0);
        chk("rstmid_addr", dbus_if.addr, 0);
        rst = 1'b0;
        nop();
        tick();
        chk("rstmid_idle_noreq", dbus_if.req, 0);
        set_op(EXE_LBU_OP, 32'h0000_5000, 32'h0);
        tick();
        chk("lbu5_sel", dbus_if.sel, 4'b1000);
        dbus_if.ack = 1'b1;
        dbus_if.rdata = 32'h8012_3456;
        tick();
        dbus_if.ack = 1'b0;
        #1;
        chk("lbu5_wb_wdata", wb_wdata, 32'h0000_0080);
        nop();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
